// File: rtl/snes_joy_pkg.sv
// Shared types and constants for the SNES automatic joypad read sequencer.
package snes_joy_pkg;

  // Sequencer phases: strobe the pads, then 16 low/high clock pairs, then a one-cycle commit.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } joy_state_t;

  // Each port line delivers a 16-bit button word per read.
  localparam int JOY_BITS = 16;

  // Default timing, in CE ticks.
  localparam logic [7:0] DEF_LATCH_TICKS = 8'd12;
  localparam logic [7:0] DEF_HALF_TICKS  = 8'd6;

  // Converts a tick count into the down-counter reload value; a count of 0 behaves like 1.
  function automatic logic [7:0] ticks_to_load(input logic [7:0] ticks);
    logic [7:0] w_load;
    w_load = (ticks == 8'd0) ? 8'd0 : (ticks - 8'd1);
    return w_load;
  endfunction

endpackage

// File: rtl/snes_joy_tick_timer.sv
// Loadable 8-bit down-counter that times each sequencer phase in CE ticks.
// o_last is high on the CE tick that ends the current phase (count already at zero).
module snes_joy_tick_timer (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ce,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic       o_last
);

  logic [7:0] r_count;

  // Reload on phase entry, otherwise count down once per CE tick and rest at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_ce && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_last = i_ce && (r_count == 8'd0);

endmodule

// File: rtl/snes_autojoy.sv
// SNES automatic joypad read sequencer.
// At vblank start (when enabled) it strobes both controller ports, clocks 16 bits out of
// each of the four data lines, and publishes them as JOY1..JOY4 once the whole read is done.
// While idle it forwards the CPU's manual strobe level and read-clock pulses to the ports.
module snes_autojoy
  import snes_joy_pkg::*;
#(
  parameter logic [7:0] LATCH_TICKS = DEF_LATCH_TICKS,
  parameter logic [7:0] HALF_TICKS  = DEF_HALF_TICKS
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ce,
  input  logic                i_enable,
  input  logic                i_vblank_start,
  input  logic                i_cpu_strobe,
  input  logic                i_cpu_rd1,
  input  logic                i_cpu_rd2,
  input  logic [1:0]          i_port1_do,
  input  logic [1:0]          i_port2_do,
  output logic                o_port_latch,
  output logic                o_port1_clk,
  output logic                o_port2_clk,
  output logic [JOY_BITS-1:0] o_joy1,
  output logic [JOY_BITS-1:0] o_joy2,
  output logic [JOY_BITS-1:0] o_joy3,
  output logic [JOY_BITS-1:0] o_joy4,
  output logic                o_busy
);

  localparam logic [7:0] LATCH_LOAD = ticks_to_load(LATCH_TICKS);
  localparam logic [7:0] HALF_LOAD  = ticks_to_load(HALF_TICKS);

  joy_state_t r_state;
  joy_state_t w_state_next;

  logic [3:0] r_bit_cnt;

  logic [JOY_BITS-1:0] r_shadow1;
  logic [JOY_BITS-1:0] r_shadow2;
  logic [JOY_BITS-1:0] r_shadow3;
  logic [JOY_BITS-1:0] r_shadow4;

  logic [JOY_BITS-1:0] r_joy1;
  logic [JOY_BITS-1:0] r_joy2;
  logic [JOY_BITS-1:0] r_joy3;
  logic [JOY_BITS-1:0] r_joy4;

  logic r_busy;
  logic r_port_latch;
  logic r_port1_clk;
  logic r_port2_clk;

  logic       w_start;
  logic       w_sample;
  logic       w_bit_advance;
  logic       w_commit;
  logic       w_tick_last;
  logic       w_tick_load;
  logic [7:0] w_tick_val;
  logic       w_busy_next;
  logic       w_manual_ok;
  logic       w_auto_latch;
  logic       w_auto_clk;

  // One shared phase timer, reloaded whenever the sequencer enters a new phase.
  snes_joy_tick_timer u_tick_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ce       (i_ce),
    .i_load     (w_tick_load),
    .i_load_val (w_tick_val),
    .o_last     (w_tick_last)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus the per-edge strobes (start, sample, bit advance, commit).
  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_sample      = 1'b0;
    w_bit_advance = 1'b0;
    w_commit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_vblank_start && i_enable) begin
          w_state_next = LATCH;
          w_start      = 1'b1;
        end
      end
      LATCH: begin
        if (w_tick_last) begin
          w_state_next = LOW;
        end
      end
      LOW: begin
        if (w_tick_last) begin
          w_state_next = HIGH;
          w_sample     = 1'b1;
        end
      end
      HIGH: begin
        if (w_tick_last) begin
          if (r_bit_cnt == 4'd15) begin
            w_state_next = DONE;
          end else begin
            w_state_next  = LOW;
            w_bit_advance = 1'b1;
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
        w_commit     = 1'b1;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Timer reload value for the phase being entered.
  always_comb begin
    w_tick_load = (w_state_next != r_state);
    w_tick_val  = 8'd0;
    case (w_state_next)
      LATCH:   w_tick_val = LATCH_LOAD;
      LOW:     w_tick_val = HALF_LOAD;
      HIGH:    w_tick_val = HALF_LOAD;
      default: w_tick_val = 8'd0;
    endcase
  end

  // Bit counter: advances after each completed high phase, returns to zero on commit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt <= 4'd0;
    end else if (w_commit) begin
      r_bit_cnt <= 4'd0;
    end else if (w_bit_advance) begin
      r_bit_cnt <= r_bit_cnt + 4'd1;
    end
  end

  // Shadow registers collect the active-high bits, first bit ending up in the MSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow1 <= '0;
      r_shadow2 <= '0;
      r_shadow3 <= '0;
      r_shadow4 <= '0;
    end else if (w_start) begin
      r_shadow1 <= '0;
      r_shadow2 <= '0;
      r_shadow3 <= '0;
      r_shadow4 <= '0;
    end else if (w_sample) begin
      r_shadow1 <= {r_shadow1[JOY_BITS-2:0], ~i_port1_do[0]};
      r_shadow2 <= {r_shadow2[JOY_BITS-2:0], ~i_port2_do[0]};
      r_shadow3 <= {r_shadow3[JOY_BITS-2:0], ~i_port1_do[1]};
      r_shadow4 <= {r_shadow4[JOY_BITS-2:0], ~i_port2_do[1]};
    end
  end

  // Published button words only change on the commit edge, so partial reads never show.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_joy1 <= '0;
      r_joy2 <= '0;
      r_joy3 <= '0;
      r_joy4 <= '0;
    end else if (w_commit) begin
      r_joy1 <= r_shadow1;
      r_joy2 <= r_shadow2;
      r_joy3 <= r_shadow3;
      r_joy4 <= r_shadow4;
    end
  end

  // Port-side values for the upcoming cycle. Manual read pulses are honoured only when the
  // sequencer was idle and stays idle, so a coincident vblank start drops them.
  always_comb begin
    w_busy_next  = (w_state_next != IDLE);
    w_manual_ok  = (r_state == IDLE) && (w_state_next == IDLE);
    w_auto_latch = (w_state_next == LATCH);
    w_auto_clk   = (w_state_next == HIGH);
  end

  // Registered BUSY flag and port strobe/clock muxing between auto-read and CPU control.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy       <= 1'b0;
      r_port_latch <= 1'b0;
      r_port1_clk  <= 1'b0;
      r_port2_clk  <= 1'b0;
    end else begin
      r_busy       <= w_busy_next;
      r_port_latch <= w_busy_next ? w_auto_latch : i_cpu_strobe;
      r_port1_clk  <= w_manual_ok ? i_cpu_rd1 : w_auto_clk;
      r_port2_clk  <= w_manual_ok ? i_cpu_rd2 : w_auto_clk;
    end
  end

  assign o_busy       = r_busy;
  assign o_port_latch = r_port_latch;
  assign o_port1_clk  = r_port1_clk;
  assign o_port2_clk  = r_port2_clk;
  assign o_joy1       = r_joy1;
  assign o_joy2       = r_joy2;
  assign o_joy3       = r_joy3;
  assign o_joy4       = r_joy4;

endmodule

// File: tb/tb_snes_autojoy.sv
// Testbench for snes_autojoy: directed scenarios with literal expectations plus a randomized
// phase, all checked every cycle against a tick-counting reference model and an ioport model.
module tb_snes_autojoy;

  localparam int LATCH = 12;
  localparam int HALF  = 6;
  localparam int TOTAL = LATCH + 32 * HALF;

  logic clk = 1'b0;
  logic rstN = 1'b1;
  logic ce = 1'b1;
  logic enable = 1'b0;
  logic vblank = 1'b0;
  logic cpuStrobe = 1'b0;
  logic cpuRd1 = 1'b0;
  logic cpuRd2 = 1'b0;
  logic [1:0] port1Do;
  logic [1:0] port2Do;
  logic portLatch;
  logic portClk1;
  logic portClk2;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic [15:0] joy3;
  logic [15:0] joy4;
  logic busy;

  int total = 0;
  int bad = 0;
  bit checkOn = 1'b0;

  // Pad contents, active-high, bit 15 is shifted out first:
  // [0]=port1 line0, [1]=port2 line0, [2]=port1 line1 (multitap), [3]=port2 line1.
  logic [15:0] pads [4];
  int idx1 = 0;
  int idx2 = 0;
  logic prevPClk1 = 1'b0;
  logic prevPClk2 = 1'b0;

  always #5 clk = ~clk;

  snes_autojoy dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_ce           (ce),
    .i_enable       (enable),
    .i_vblank_start (vblank),
    .i_cpu_strobe   (cpuStrobe),
    .i_cpu_rd1      (cpuRd1),
    .i_cpu_rd2      (cpuRd2),
    .i_port1_do     (port1Do),
    .i_port2_do     (port2Do),
    .o_port_latch   (portLatch),
    .o_port1_clk    (portClk1),
    .o_port2_clk    (portClk2),
    .o_joy1         (joy1),
    .o_joy2         (joy2),
    .o_joy3         (joy3),
    .o_joy4         (joy4),
    .o_busy         (busy)
  );

  function automatic logic bitOf(input logic [15:0] v, input int idx);
    if (idx < 16) return v[15 - idx];
    return 1'b1;
  endfunction

  // Controller ports: active-low data; strobe rewinds, each rising port clock advances one bit.
  assign port1Do = {~bitOf(pads[2], idx1), ~bitOf(pads[0], idx1)};
  assign port2Do = {~bitOf(pads[3], idx2), ~bitOf(pads[1], idx2)};

  always @(negedge clk) begin
    if (portLatch) begin
      idx1 = 0;
      idx2 = 0;
    end else begin
      if (portClk1 && !prevPClk1 && idx1 < 16) idx1++;
      if (portClk2 && !prevPClk2 && idx2 < 16) idx2++;
    end
    prevPClk1 = portClk1;
    prevPClk2 = portClk2;
  end

  // Reference model: counts CE ticks since the sequence began and derives every output from
  // that count (strobe for the first LATCH ticks, then alternating HALF-tick low/high phases,
  // then one commit cycle).
  bit mActive;
  int mTicks;
  logic [15:0] mSnap [4];
  logic [15:0] mJoy [4];
  logic expBusy, expLatch, expClk1, expClk2;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mActive = 1'b0;
      mTicks = 0;
      expBusy = 1'b0;
      expLatch = 1'b0;
      expClk1 = 1'b0;
      expClk2 = 1'b0;
      for (int k = 0; k < 4; k++) begin
        mSnap[k] = '0;
        mJoy[k] = '0;
      end
    end else begin
      bit wasIdle;
      wasIdle = !mActive;
      if (wasIdle) begin
        if (vblank && enable) begin
          mActive = 1'b1;
          mTicks = 0;
          for (int k = 0; k < 4; k++) mSnap[k] = pads[k];
        end
      end else if (mTicks < TOTAL) begin
        if (ce) mTicks++;
      end else begin
        mActive = 1'b0;
        for (int k = 0; k < 4; k++) mJoy[k] = mSnap[k];
      end
      expBusy = mActive;
      if (mActive) begin
        expLatch = (mTicks < LATCH);
        expClk1 = (mTicks >= LATCH) && (mTicks < TOTAL) && (((mTicks - LATCH) / HALF) % 2 == 1);
        expClk2 = expClk1;
      end else begin
        expLatch = cpuStrobe;
        expClk1 = wasIdle && cpuRd1;
        expClk2 = wasIdle && cpuRd2;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("busy", busy, expBusy);
      checkOutput("portLatch", portLatch, expLatch);
      checkOutput("port1Clk", portClk1, expClk1);
      checkOutput("port2Clk", portClk2, expClk2);
      checkOutput("joy1", joy1, mJoy[0]);
      checkOutput("joy2", joy2, mJoy[1]);
      checkOutput("joy3", joy3, mJoy[2]);
      checkOutput("joy4", joy4, mJoy[3]);
    end
  end

  // Pulse VBLANK_START in cycle 0 and observe cycles 1..maxCycles; optionally re-pulse it.
  task automatic runSequence(input int maxCycles, input int extraVblankAt,
                             output int busyCycles, output int latchCycles,
                             output int rises1, output int rises2, output int fallCycle);
    logic p1, p2;
    bit seenBusy;
    busyCycles = 0;
    latchCycles = 0;
    rises1 = 0;
    rises2 = 0;
    fallCycle = -1;
    seenBusy = 1'b0;
    @(posedge clk);
    #1 vblank = 1'b1;
    p1 = portClk1;
    p2 = portClk2;
    @(posedge clk);
    #1 vblank = 1'b0;
    for (int c = 1; c <= maxCycles; c++) begin
      @(negedge clk);
      if (busy) begin
        busyCycles++;
        seenBusy = 1'b1;
      end else if (seenBusy && fallCycle < 0) begin
        fallCycle = c;
      end
      if (portLatch) latchCycles++;
      if (portClk1 && !p1) rises1++;
      if (portClk2 && !p2) rises2++;
      p1 = portClk1;
      p2 = portClk2;
      vblank = (c == extraVblankAt);
    end
    vblank = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idleTimeout", busy, 1'b0);
  endtask

  // One randomized cycle of inputs; pads only change while no read is in flight.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    ce = ($urandom_range(0, 3) != 0);
    enable = ($urandom_range(0, 7) != 0);
    vblank = ($urandom_range(0, 149) == 0);
    if ($urandom_range(0, 19) == 0) cpuStrobe = ~cpuStrobe;
    cpuRd1 = ($urandom_range(0, 7) == 0);
    cpuRd2 = ($urandom_range(0, 7) == 0);
    if (!mActive && $urandom_range(0, 9) == 0) begin
      for (int k = 0; k < 4; k++) pads[k] = 16'($urandom);
    end
  endtask

  int busyN, latchN, r1, r2, fallC, hi1, hi2, oddCnt;

  initial begin
    for (int k = 0; k < 4; k++) pads[k] = 16'h0000;
    #2 rstN = 1'b0;
    checkOn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", busy, 1'b0);
    checkOutput("resetJoy1", joy1, 16'h0000);
    checkOutput("resetLatch", portLatch, 1'b0);
    #2 rstN = 1'b1;
    enable = 1'b1;
    ce = 1'b1;

    // Only port1 line0 pressed on the first bit.
    pads[0] = 16'h8000;
    runSequence(230, -1, busyN, latchN, r1, r2, fallC);
    checkOutput("t1BusyCycles", busyN, 205);
    checkOutput("t1BusyFall", fallC, 206);
    checkOutput("t1LatchCycles", latchN, 12);
    checkOutput("t1Rises1", r1, 16);
    checkOutput("t1Rises2", r2, 16);
    checkOutput("t1Joy1", joy1, 16'h8000);
    checkOutput("t1Joy2", joy2, 16'h0000);
    checkOutput("t1Joy3", joy3, 16'h0000);
    checkOutput("t1Joy4", joy4, 16'h0000);

    // Multitap patterns on port 1, distinct patterns on port 2.
    pads[0] = 16'hA5F0;
    pads[2] = 16'h0F0F;
    pads[1] = 16'h1234;
    pads[3] = 16'h8001;
    runSequence(230, -1, busyN, latchN, r1, r2, fallC);
    checkOutput("t2Joy1", joy1, 16'hA5F0);
    checkOutput("t2Joy3", joy3, 16'h0F0F);
    checkOutput("t2Joy2", joy2, 16'h1234);
    checkOutput("t2Joy4", joy4, 16'h8001);

    // Auto-read disabled: nothing happens.
    enable = 1'b0;
    pads[0] = 16'hFFFF;
    runSequence(40, -1, busyN, latchN, r1, r2, fallC);
    checkOutput("t3Busy", busyN, 0);
    checkOutput("t3Rises1", r1, 0);
    checkOutput("t3Rises2", r2, 0);
    checkOutput("t3Joy1", joy1, 16'hA5F0);
    enable = 1'b1;

    // Second vblank during the read is ignored.
    pads[0] = 16'h5A5A;
    runSequence(230, 50, busyN, latchN, r1, r2, fallC);
    checkOutput("t4BusyFall", fallC, 206);
    checkOutput("t4BusyCycles", busyN, 205);
    checkOutput("t4Joy1", joy1, 16'h5A5A);

    // Manual strobe and read clocks while idle.
    @(posedge clk);
    #1 cpuStrobe = 1'b1;
    @(negedge clk);
    checkOutput("manLatchLag", portLatch, 1'b0);
    @(negedge clk);
    checkOutput("manLatchHigh", portLatch, 1'b1);
    @(posedge clk);
    #1 cpuStrobe = 1'b0;
    @(negedge clk);
    checkOutput("manLatchHold", portLatch, 1'b1);
    @(negedge clk);
    checkOutput("manLatchLow", portLatch, 1'b0);
    hi1 = 0;
    hi2 = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 cpuRd2 = (i == 0 || i == 2 || i == 4);
      @(negedge clk);
      if (portClk1) hi1++;
      if (portClk2) hi2++;
    end
    cpuRd2 = 1'b0;
    checkOutput("manRd2Pulses", hi2, 3);
    checkOutput("manRd1Quiet", hi1, 0);

    // Same manual activity during the strobe phase of a read has no effect.
    @(posedge clk);
    #1 vblank = 1'b1;
    @(posedge clk);
    #1 vblank = 1'b0;
    hi1 = 0;
    oddCnt = 0;
    for (int i = 1; i <= 11; i++) begin
      cpuStrobe = i[0];
      cpuRd2 = i[0];
      cpuRd1 = (i == 5);
      @(negedge clk);
      if (portClk1 || portClk2) hi1++;
      if (!portLatch) oddCnt++;
      @(posedge clk);
      #1;
    end
    cpuStrobe = 1'b0;
    cpuRd1 = 1'b0;
    cpuRd2 = 1'b0;
    checkOutput("busyManClk", hi1, 0);
    checkOutput("busyManLatch", oddCnt, 0);
    waitIdle(400);

    // Reset in the middle of a read.
    pads[0] = 16'h3C3C;
    runSequence(100, -1, busyN, latchN, r1, r2, fallC);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstLatch", portLatch, 1'b0);
    checkOutput("rstClk1", portClk1, 1'b0);
    checkOutput("rstClk2", portClk2, 1'b0);
    checkOutput("rstJoy1", joy1, 16'h0000);
    checkOutput("rstJoy4", joy4, 16'h0000);
    @(negedge clk);
    #2 rstN = 1'b1;
    pads[0] = 16'hC3A1;
    pads[3] = 16'h7E01;
    runSequence(230, -1, busyN, latchN, r1, r2, fallC);
    checkOutput("postRstFall", fallC, 206);
    checkOutput("postRstJoy1", joy1, 16'hC3A1);
    checkOutput("postRstJoy4", joy4, 16'h7E01);

    // Randomized phase, with one extra asynchronous reset.
    for (int i = 0; i < 6000; i++) begin
      applyStimulus();
      if (i == 3000) begin
        @(negedge clk);
        #2 rstN = 1'b0;
        @(negedge clk);
        #2 rstN = 1'b1;
      end
    end
    ce = 1'b1;
    vblank = 1'b0;
    cpuRd1 = 1'b0;
    cpuRd2 = 1'b0;
    waitIdle(400);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snes_autojoy.md
Name: snes_autojoy

Overview:
Sequencer that performs the SNES automatic joypad read at vblank start. It drives the shared controller-port strobe and the per-port clock lines into the ioport datapath. It shifts in 16 bits from each of the four data lines (two per port, multitap on bit 1) and publishes JOY1..JOY4 with a BUSY flag ($4212 bit0). When idle, it passes CPU manual strobe writes and read clocks ($4016/$4017) through to the ports.

Parameters:
LATCH_TICKS, 12, CE ticks that STROBE stays high; 8-bit; 0 is treated as 1
HALF_TICKS, 6, CE ticks per clock half-phase (low and high); 8-bit; 0 is treated as 1

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
CE  in  1  timing tick enable; all tick counters advance only when CE=1
ENABLE  in  1  auto-read enable (NMITIMEN bit0)
VBLANK_START  in  1  one-CLK pulse at vblank start
CPU_STROBE  in  1  CPU-written $4016 bit0 level
CPU_RD1  in  1  one-CLK pulse, CPU read of $4016
CPU_RD2  in  1  one-CLK pulse, CPU read of $4017
PORT1_DO  in  2  port 1 data lines, active-low
PORT2_DO  in  2  port 2 data lines, active-low
PORT_LATCH  out  1  strobe to both ports
PORT1_CLK  out  1  port 1 shift clock; a rising edge shifts the port
PORT2_CLK  out  1  port 2 shift clock
JOY1  out  16  port1 DO[0], active-high, first bit in MSB
JOY2  out  16  port2 DO[0]
JOY3  out  16  port1 DO[1]
JOY4  out  16  port2 DO[1]
BUSY  out  1  auto-read in progress

Behaviour:
- Reset: all outputs are 0; FSM is IDLE; bit counter, tick counter and shadow registers are 0. Reset asserted mid-sequence aborts the sequence, leaves JOYn at 0, and all outputs drop low asynchronously.
- States:
  - IDLE: if VBLANK_START and ENABLE are both 1, go to LATCH. Shadow registers are cleared on that same edge.
  - LATCH: auto strobe is 1 for LATCH_TICKS CE ticks, then go to LOW.
  - LOW: clock is 0 for HALF_TICKS ticks. On the final tick, sample shadowN <= {shadowN[14:0], ~DO}, then go to HIGH.
  - HIGH: clock is 1 on both ports for HALF_TICKS ticks. On the final tick, go to DONE if bit_cnt==15; otherwise increment bit_cnt and go to LOW.
  - DONE: clocks are 0; lasts one CLK cycle regardless of CE. On the exit edge to IDLE, JOY1..4 <= shadows and BUSY falls on that same edge.
- BUSY is registered and equals (state != IDLE). It rises on the edge after the VBLANK_START sample, i.e. 1-cycle latency.
- With CE=1 constantly: BUSY is high for LATCH_TICKS + 32*HALF_TICKS + 1 cycles, which is 205 cycles at the defaults.
- JOYn outputs hold their previous values throughout a sequence; partial values are never visible.
- Output muxing, all registered:
  - PORT_LATCH = BUSY ? auto strobe : CPU_STROBE.
  - PORTx_CLK = BUSY ? auto clock : one-CLK-cycle high pulse following CPU_RDx.
- Boundary conditions:
  - VBLANK_START while BUSY: ignored.
  - ENABLE deasserted mid-sequence: the sequence completes and commits.
  - CPU_RDx or CPU_STROBE changes while BUSY: ignored; no queuing.
  - CPU_RD1 and CPU_RD2 in the same cycle while idle: both clocks pulse together.
  - VBLANK_START coincident with CPU_RDx while idle: the auto-read wins and the manual pulse is dropped.
  - CE=0: the FSM freezes in every state except DONE and IDLE.
- Tick counter is 8-bit and loads (TICKS-1) on state entry. bit_cnt is 4-bit and wraps only via reset or the DONE path.

Decomposition:
- Package snes_joy_pkg:
  - state enum (IDLE, LATCH, LOW, HIGH, DONE);
  - JOY_BITS=16 constant;
  - default tick constants.
- Sub-module snes_joy_tick_timer: loadable 8-bit down-counter with CE gating and a last-tick output. Instantiated once and reloaded on each state entry.

Test Plan:
- CE=1 at defaults, ENABLE=1, VBLANK_START pulse at cycle 0; port1 DO[0] low only on the first bit, all other lines high. Required: BUSY high for cycles 1..205, JOY1=16'h8000, JOY2=JOY3=JOY4=0, exactly 16 rising edges on each PORTx_CLK, PORT_LATCH high for 12 cycles.
- ioport model on port 1 with multitap and joystick bits giving pattern 16'hA5F0 on DO[0] and 16'h0F0F on DO[1]. Required: JOY1=16'hA5F0, JOY3=16'h0F0F after BUSY falls.
- ENABLE=0 with VBLANK_START pulse. Required: BUSY stays 0, no clock edges, JOYn unchanged.
- Second VBLANK_START at cycle 50 of a sequence. Required: ignored, BUSY still falls at cycle 206, single commit.
- Idle: CPU_STROBE=1 then 0, then three CPU_RD2 pulses. Required: PORT_LATCH follows with 1-cycle latency; PORT2_CLK shows three 1-cycle highs; PORT1_CLK stays 0. The same stimulus while BUSY produces no effect.
- RESET_N low at cycle 100 of a sequence. Required: immediate BUSY=0, PORT_LATCH=0, clocks=0, JOYn=0. A new VBLANK_START after release runs a full, correct sequence.
